// File: rtl/irrigation_pkg.sv
// irrigation_pkg: shared state encoding, default timing and decode helpers for irrigation blocks
package irrigation_pkg;

    typedef enum logic [2:0] {
        IDLE,
        OPEN_VALVE,
        RUN,
        STOP_PUMP,
        COOLDOWN,
        FAULT
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES     = 3;
    localparam int DEF_VALVE_SETTLE_CYCLES = 4;
    localparam int DEF_MIN_RUN_CYCLES      = 16;
    localparam int DEF_COOLDOWN_CYCLES     = 8;

    function automatic logic valve_phase(input state_t s);
        return (s == OPEN_VALVE) || (s == RUN) || (s == STOP_PUMP);
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// input_debouncer: accepts a new level only after LEN consecutive differing samples
module input_debouncer
    import irrigation_pkg::*;
#(
    parameter int LEN = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    if (LEN < 1 || LEN > 255) begin : g_bad_len
        $error("input_debouncer: LEN must be in 1..255");
    end

    localparam logic [7:0] LAST = 8'(LEN - 1);

    logic [7:0] cnt;

    // count consecutive samples that disagree with the accepted level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= 1'b0;
            cnt <= '0;
        end else if (d == q) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            q   <= d;
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/irrigation_actuator_sequencer.sv
// irrigation_actuator_sequencer: sequences valve, pump and cooldown phases with low-water fault handling
module irrigation_actuator_sequencer
    import irrigation_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
    parameter int VALVE_SETTLE_CYCLES = DEF_VALVE_SETTLE_CYCLES,
    parameter int MIN_RUN_CYCLES      = DEF_MIN_RUN_CYCLES,
    parameter int COOLDOWN_CYCLES     = DEF_COOLDOWN_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irrigation,
    input  logic sprinkler_mode,
    input  logic low_water_level,
    input  logic fault_clear,
    output logic dripper_valve,
    output logic sprinkler_valve,
    output logic pump,
    output logic busy,
    output logic fault
);

    if (VALVE_SETTLE_CYCLES < 1 || VALVE_SETTLE_CYCLES > 255 ||
        MIN_RUN_CYCLES < 1 || MIN_RUN_CYCLES > 255 ||
        COOLDOWN_CYCLES < 1 || COOLDOWN_CYCLES > 255) begin : g_bad_timing
        $error("irrigation_actuator_sequencer: timing parameters must be in 1..255");
    end

    localparam logic [7:0] SETTLE_LD = 8'(VALVE_SETTLE_CYCLES - 1);
    localparam logic [7:0] RUN_LD    = 8'(MIN_RUN_CYCLES - 1);
    localparam logic [7:0] COOL_LD   = 8'(COOLDOWN_CYCLES - 1);

    logic       req;
    state_t     state, nxt;
    logic [7:0] cnt, nxt_cnt;
    logic       mode, nxt_mode;

    input_debouncer #(.LEN(DEBOUNCE_CYCLES)) u_irrigation_debouncer (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (irrigation),
        .q    (req)
    );

    // next state: phase counters load on entry and saturate at zero; low water overrides any active phase
    always_comb begin
        nxt      = state;
        nxt_cnt  = (cnt == 8'd0) ? cnt : cnt - 8'd1;
        nxt_mode = mode;
        unique case (state)
            IDLE: if (req && low_water_level) begin
                nxt      = OPEN_VALVE;
                nxt_cnt  = SETTLE_LD;
                nxt_mode = sprinkler_mode;
            end
            OPEN_VALVE: if (!low_water_level) begin
                nxt     = FAULT;
                nxt_cnt = '0;
            end else if (cnt == 8'd0) begin
                nxt     = RUN;
                nxt_cnt = RUN_LD;
            end
            RUN: if (!low_water_level) begin
                nxt     = FAULT;
                nxt_cnt = '0;
            end else if (cnt == 8'd0 && !req) begin
                nxt     = STOP_PUMP;
                nxt_cnt = SETTLE_LD;
            end
            STOP_PUMP: if (!low_water_level) begin
                nxt     = FAULT;
                nxt_cnt = '0;
            end else if (cnt == 8'd0) begin
                nxt     = COOLDOWN;
                nxt_cnt = COOL_LD;
            end
            COOLDOWN: if (cnt == 8'd0) begin
                nxt     = IDLE;
                nxt_cnt = '0;
            end
            FAULT: if (fault_clear && low_water_level) begin
                nxt     = IDLE;
                nxt_cnt = '0;
            end
            default: begin
                nxt     = IDLE;
                nxt_cnt = '0;
            end
        endcase
    end

    // state register with outputs decoded from the next state so they are glitch-free registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            mode            <= 1'b0;
            dripper_valve   <= 1'b0;
            sprinkler_valve <= 1'b0;
            pump            <= 1'b0;
            busy            <= 1'b0;
            fault           <= 1'b0;
        end else begin
            state           <= nxt;
            cnt             <= nxt_cnt;
            mode            <= nxt_mode;
            dripper_valve   <= valve_phase(nxt) && !nxt_mode;
            sprinkler_valve <= valve_phase(nxt) && nxt_mode;
            pump            <= nxt == RUN;
            busy            <= nxt != IDLE;
            fault           <= nxt == FAULT;
        end
    end

endmodule

// File: doc/irrigation_actuator_sequencer.md
IRRIGATION_ACTUATOR_SEQUENCER -- requirements
Module: irrigation_actuator_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 3: consecutive identical samples needed to accept a change of the irrigation request.
REQ-002 Parameter VALVE_SETTLE_CYCLES, default 4: cycles a valve is open before the pump starts, and after it stops.
REQ-003 Parameter MIN_RUN_CYCLES, default 16: minimum number of pump-on cycles per irrigation run.
REQ-004 Parameter COOLDOWN_CYCLES, default 8: all-off dwell after a run before a new run may start.
REQ-005 clk  input  1  single system clock, rising edge.
REQ-006 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-007 irrigation  input  1  irrigation permit from the pre-requisite check; 1 = irrigate.
REQ-008 sprinkler_mode  input  1  actuator select; 0 = dripper, 1 = sprinkler.
REQ-009 low_water_level  input  1  raw low-level sensor; 0 = critical water level.
REQ-010 fault_clear  input  1  single-cycle request to leave FAULT.
REQ-011 dripper_valve  output  1  dripper valve open.
REQ-012 sprinkler_valve  output  1  sprinkler valve open.
REQ-013 pump  output  1  pump motor on.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 fault  output  1  high only in FAULT.

Function
REQ-016 The block SHALL debounce irrigation: the internal request changes only after DEBOUNCE_CYCLES consecutive samples that differ from its current value; it resets to 0.
REQ-017 The FSM SHALL have the states IDLE, OPEN_VALVE, RUN, STOP_PUMP, COOLDOWN and FAULT; all outputs are Moore outputs decoded from registered state.
REQ-018 IDLE -> OPEN_VALVE SHALL occur when the debounced request is 1 and low_water_level = 1; sprinkler_mode is latched on that same edge.
REQ-019 The latched mode SHALL select which single valve is open in OPEN_VALVE, RUN and STOP_PUMP; mode changes during a run are ignored.
REQ-020 OPEN_VALVE SHALL last exactly VALVE_SETTLE_CYCLES cycles, then move to RUN.
REQ-021 pump SHALL be 1 only in RUN, so the pump never runs with both valves closed.
REQ-022 RUN SHALL last at least MIN_RUN_CYCLES cycles; it exits to STOP_PUMP on the first cycle in which the debounced request is 0 and the minimum has elapsed.
REQ-023 STOP_PUMP SHALL last exactly VALVE_SETTLE_CYCLES cycles with the valve still open, then move to COOLDOWN.
REQ-024 COOLDOWN SHALL hold all actuators off for exactly COOLDOWN_CYCLES cycles regardless of the request, then move to IDLE.
REQ-025 low_water_level = 0 in OPEN_VALVE, RUN or STOP_PUMP SHALL force FAULT on the next edge, overriding the minimum run time; all actuators are off in FAULT.
REQ-026 FAULT -> IDLE SHALL occur only when fault_clear = 1 and low_water_level = 1 in the same cycle; fault_clear in any other state has no effect.
REQ-027 Phase counters SHALL be 8-bit unsigned, load on state entry and never wrap; parameter values of 0 SHALL be rejected at elaboration, and the legal range is 1..255.
REQ-028 When a request returns within the debounce window, it SHALL produce no state change.

Reset
REQ-029 On rst_n = 0 the block SHALL immediately enter IDLE, with all outputs 0, counters 0, debounced request 0 and latched mode 0, including mid-run (valves and pump drop asynchronously).
REQ-030 After rst_n rises, a run SHALL require a fresh full debounce of the irrigation request.

Structure
REQ-031 The state encoding and the default timing constants SHALL reside in a shared package, irrigation_pkg, for reuse by the other irrigation blocks.
REQ-032 The debounce logic SHALL be one sub-module, input_debouncer (parameterised on length), instantiated once for irrigation.

Verification
REQ-033 Default parameters; irrigation=1, mode=0 held -> busy at +3 cycles, dripper_valve for 4 cycles, pump for ≥16 cycles, sprinkler_valve never 1.
REQ-034 irrigation pulses high for 2 cycles -> no state change, all outputs stay 0.
REQ-035 Request dropped at the 5th RUN cycle -> pump stays on until the 16th RUN cycle, then 4 valve-only cycles, then 8 all-off cycles with busy=1, then IDLE.
REQ-036 low_water_level=0 at the 10th RUN cycle -> next cycle pump=0, valves=0, fault=1; fault_clear while low_water_level=0 is ignored; fault_clear with level=1 -> IDLE.
REQ-037 mode=1 latched, mode toggled during RUN -> only sprinkler_valve is ever high in that run.
REQ-038 rst_n pulsed low during RUN -> outputs 0 without waiting for a clock edge; after release, a new run starts only after 3 stable request cycles.
